// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
// Multiplexed N-digit 7-segment display driver. A free-running prescaler
// divides each digit slot into 2^DIV_W clock cycles. The sequencer steps to
// the next enabled digit at the end of every slot, skipping disabled digits.
// The anode of the current digit is driven for the part of the slot selected
// by the brightness input. The first cycle of every slot is a guard cycle
// with all anodes off, so the segments of the old digit never ghost onto the
// new one. Leading zero digits can be blanked.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          synchronous active-high reset
//   i_values       hex nibble per digit, digit i = i_values[4i+3:4i], digit 0 rightmost
//   i_dp           decimal point request per digit (1 = lit)
//   i_digit_en     per-digit enable; disabled digits are skipped
//   i_brightness   0 = dark, all-ones = full on, otherwise duty ~ brightness/2^BRIGHT_W
//   i_lz_blank     1 = blank leading zero digits (digit 0 is never blanked)
//   o_an           anode drives, polarity set by ANODE_ACTIVE_LOW
//   o_seg          segments {g,f,e,d,c,b,a}, active-low
//   o_dp_out       decimal point, active-low
//   o_digit_idx    index of the digit currently being scanned
// ---------------------------------------------------------------------------
module seven_seg_scanner #(
    parameter int NUM_DIGITS       = 4,
    parameter int DIV_W            = 17,
    parameter int BRIGHT_W         = 4,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [4*NUM_DIGITS-1:0]       i_values,
    input  logic [NUM_DIGITS-1:0]         i_dp,
    input  logic [NUM_DIGITS-1:0]         i_digit_en,
    input  logic [BRIGHT_W-1:0]           i_brightness,
    input  logic                          i_lz_blank,
    output logic [NUM_DIGITS-1:0]         o_an,
    output logic [6:0]                    o_seg,
    output logic                          o_dp_out,
    output logic [$clog2(NUM_DIGITS)-1:0] o_digit_idx
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    // All anodes off. XOR-ing a one-hot select with this gives the active
    // drive pattern for either polarity.
    localparam logic [NUM_DIGITS-1:0] AN_INACTIVE = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};

    logic [DIV_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_digit_idx;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;
    logic                  r_dp_out;

    logic                  w_tick;
    logic [IDX_W-1:0]      w_next_idx;
    logic                  w_found;
    logic [3:0]            w_nibble;
    logic                  w_en_cur;
    logic                  w_dp_cur;
    logic                  w_blank_cur;
    logic [NUM_DIGITS-1:0] w_blank;
    logic                  w_zero_run;
    logic                  w_bright_ok;
    logic                  w_anode_on;
    logic [NUM_DIGITS-1:0] w_an_onehot;
    logic [6:0]            w_seg_dec;

    assign w_tick = (r_cnt == {DIV_W{1'b1}});

    // Search upward from the current digit (with wrap) for the next enabled
    // one. The last candidate examined is the current digit itself, so a lone
    // enabled digit keeps the scan in place; with nothing enabled the index
    // simply holds.
    always_comb begin
        w_next_idx = r_digit_idx;
        w_found    = 1'b0;
        for (int k = 1; k <= NUM_DIGITS; k++) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'((int'(r_digit_idx) + k) % NUM_DIGITS);
            if (!w_found && i_digit_en[cand]) begin
                w_next_idx = cand;
                w_found    = 1'b1;
            end
        end
    end

    // A digit is blanked when it and every digit above it hold zero.
    // The running flag walks down from the most significant digit.
    always_comb begin
        w_blank    = '0;
        w_zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (i_values[4*i +: 4] == 4'h0);
            if (i > 0) begin
                w_blank[i] = i_lz_blank && w_zero_run;
            end
        end
    end

    // Select the per-digit fields of the scanned digit with an explicit
    // compare chain so an out-of-range index can never produce X.
    always_comb begin
        w_nibble    = 4'h0;
        w_en_cur    = 1'b0;
        w_dp_cur    = 1'b0;
        w_blank_cur = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_idx == IDX_W'(i)) begin
                w_nibble    = i_values[4*i +: 4];
                w_en_cur    = i_digit_en[i];
                w_dp_cur    = i_dp[i];
                w_blank_cur = w_blank[i];
            end
        end
    end

    always_comb begin
        w_seg_dec = 7'h7F;
        case (w_nibble)
            4'h0: w_seg_dec = 7'b1000000;
            4'h1: w_seg_dec = 7'b1111001;
            4'h2: w_seg_dec = 7'b0100100;
            4'h3: w_seg_dec = 7'b0110000;
            4'h4: w_seg_dec = 7'b0011001;
            4'h5: w_seg_dec = 7'b0010010;
            4'h6: w_seg_dec = 7'b0000010;
            4'h7: w_seg_dec = 7'b1111000;
            4'h8: w_seg_dec = 7'b0000000;
            4'h9: w_seg_dec = 7'b0010000;
            4'hA: w_seg_dec = 7'b0001000;
            4'hB: w_seg_dec = 7'b0000011;
            4'hC: w_seg_dec = 7'b1000110;
            4'hD: w_seg_dec = 7'b0100001;
            4'hE: w_seg_dec = 7'b0000110;
            4'hF: w_seg_dec = 7'b0001110;
            default: w_seg_dec = 7'h7F;
        endcase
    end

    // PWM: compare the top bits of the slot counter against brightness.
    // All-ones is forced fully on because the compare alone would leave the
    // last sub-slot dark.
    assign w_bright_ok = (&i_brightness) || (r_cnt[DIV_W-1 -: BRIGHT_W] < i_brightness);

    // cnt == 0 is the anti-ghost guard cycle at the start of each slot.
    assign w_anode_on  = w_en_cur && (r_cnt != '0) && w_bright_ok;
    assign w_an_onehot = NUM_DIGITS'(1) << r_digit_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_digit_idx <= '0;
            r_an        <= AN_INACTIVE;
            r_seg       <= 7'h7F;
            r_dp_out    <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_tick) begin
                r_digit_idx <= w_next_idx;
            end
            r_an     <= w_anode_on ? (w_an_onehot ^ AN_INACTIVE) : AN_INACTIVE;
            r_seg    <= w_blank_cur ? 7'h7F : w_seg_dec;
            r_dp_out <= ~w_dp_cur;
        end
    end

    assign o_an        = r_an;
    assign o_seg       = r_seg;
    assign o_dp_out    = r_dp_out;
    assign o_digit_idx = r_digit_idx;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scanner
// Scoreboard bench for seven_seg_scanner with DIV_W=4, BRIGHT_W=4,
// NUM_DIGITS=4, active-low anodes. Inputs are driven on the falling edge,
// where a behavioural model pushes the outputs expected after the next rising
// edge. A monitor pops and compares 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_seven_seg_scanner;

    localparam int ND = 4;
    localparam int DW = 4;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   values;
    logic [3:0]    dpIn;
    logic [3:0]    digitEn;
    logic [3:0]    brightness;
    logic          lzBlank;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dpOut;
    logic [1:0]    digitIdx;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
        bit         segValid;
    } expT;

    expT sbQ[$];
    int  compareCount  = 0;
    int  mismatchCount = 0;
    int  activeCount   = 0;
    int  mCnt          = 0;
    int  mIdx          = 0;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .NUM_DIGITS      (ND),
        .DIV_W           (DW),
        .BRIGHT_W        (BW),
        .ANODE_ACTIVE_LOW(1)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_values    (values),
        .i_dp        (dpIn),
        .i_digit_en  (digitEn),
        .i_brightness(brightness),
        .i_lz_blank  (lzBlank),
        .o_an        (an),
        .o_seg       (seg),
        .o_dp_out    (dpOut),
        .o_digit_idx (digitIdx)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        if (obs !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] hexSeg(input logic [3:0] n);
        logic [6:0] tab [16];
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tab[n];
    endfunction

    // Behavioural model of one clock edge: predicts the outputs after the
    // coming rising edge from the present inputs, then advances its state.
    task automatic modelStep();
        expT e;
        if (rst) begin
            e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.idx = 2'd0; e.segValid = 1'b1;
            mCnt = 0;
            mIdx = 0;
        end else begin
            bit on;
            bit blank;
            logic [15:0] upper;
            int nIdx;
            bit found;
            on = digitEn[mIdx] && (mCnt != 0) &&
                 ((brightness == 4'hF) || ((mCnt >> (DW - BW)) < int'(brightness)));
            upper = values >> (4 * mIdx);
            blank = lzBlank && (mIdx > 0) && (upper == 16'h0);
            e.an       = on ? ~(4'b0001 << mIdx) : 4'hF;
            e.seg      = blank ? 7'h7F : hexSeg(upper[3:0]);
            e.dp       = ~dpIn[mIdx];
            e.segValid = on;
            nIdx  = mIdx;
            found = 1'b0;
            if (mCnt == (1 << DW) - 1) begin
                for (int k = 1; k <= ND; k++) begin
                    if (!found && digitEn[(mIdx + k) % ND]) begin
                        nIdx  = (mIdx + k) % ND;
                        found = 1'b1;
                    end
                end
            end
            mIdx  = nIdx;
            mCnt  = (mCnt + 1) % (1 << DW);
            e.idx = 2'(mIdx);
        end
        sbQ.push_back(e);
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            modelStep();
            @(negedge clk);
        end
    endtask

    always @(posedge clk) begin
        expT e;
        #1;
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput("an", an, e.an);
            checkOutput("digit_idx", digitIdx, e.idx);
            if (e.segValid) begin
                checkOutput("seg", seg, e.seg);
                checkOutput("dp_out", dpOut, e.dp);
            end
            if (an !== 4'hF) activeCount++;
        end
    end

    initial begin
        int guard;
        rst = 1'b1; values = 16'h0; dpIn = 4'h0; digitEn = 4'h0;
        brightness = 4'h0; lzBlank = 1'b0;
        @(negedge clk);

        $display("[TB] reset");
        applyStimulus(3);

        $display("[TB] full scan, values 1234");
        rst = 1'b0; digitEn = 4'hF; values = 16'h1234; brightness = 4'hF;
        applyStimulus(64);

        $display("[TB] skip disabled digits");
        digitEn = 4'b0101;
        applyStimulus(64);

        $display("[TB] brightness 4 and 0");
        digitEn = 4'hF; brightness = 4'd4; activeCount = 0;
        applyStimulus(64);
        checkOutput("activeCyclesBright4", activeCount, 12);
        brightness = 4'd0; activeCount = 0;
        applyStimulus(32);
        checkOutput("activeCyclesBright0", activeCount, 0);

        $display("[TB] leading zero blanking");
        brightness = 4'hF; values = 16'h0070; dpIn = 4'b1000; lzBlank = 1'b1;
        applyStimulus(64);
        lzBlank = 1'b0;
        applyStimulus(64);

        $display("[TB] all disabled, then reset mid-scan");
        digitEn = 4'h0; values = 16'hA5C9; dpIn = 4'b0101;
        applyStimulus(20);
        digitEn = 4'hF;
        guard = 0;
        while (mIdx != 2 && guard < 64) begin
            applyStimulus(1);
            guard++;
        end
        applyStimulus(5);
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        applyStimulus(40);

        @(posedge clk);
        #2;
        checkOutput("scoreboardDrained", sbQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
